rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
- Decode/operand-fetch stage directly upstream of rv_alu_v.
- Accepts a fetched instruction and its PC through a valid/ready handshake, and reads rs1/rs2 from an internal 32x32 register file.
- Generates the immediate, selects Op1/Op2, and registers opcode/funct3/funct7/Op1/Op2 for the ALU.
- Owns the register-file write port, which is driven by writeback.

Parameters:
- XLEN, 32, data/PC width.
- RESET_PC_VAL, 32'h0, value of out_pc after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard the stage contents (branch/jump redirect)
- in_valid  in  1  in_inst/in_pc valid
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write address
- wb_data  in  XLEN  write data
- out_valid  out  1  outputs valid for ALU
- out_ready  in  1  downstream accepts
- opcode  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]
- Op1  out  XLEN  ALU operand 1
- Op2  out  XLEN  ALU operand 2
- out_imm  out  XLEN  sign-extended immediate
- out_rs1_val  out  XLEN  rs1 register value
- out_rs2_val  out  XLEN  rs2 register value (store data)
- out_rd  out  5  destination register
- out_pc  out  XLEN  PC of the instruction
- out_illegal  out  1  unsupported opcode

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset state: out_valid=0, out_illegal=0; Op1, Op2, out_imm, out_rs1_val, out_rs2_val, opcode, funct3, funct7 and out_rd all 0; out_pc=RESET_PC_VAL; all register-file entries cleared to 0.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Outputs are registered and appear 1 cycle after accept.
  - Full throughput: one instruction per cycle.
- Stall: while out_valid && !out_ready, every output is held stable and in_ready=0.
- out_valid update: set on accept; cleared when out_ready && !accept.
- Flush (synchronous, priority over accept): out_valid<=0 next cycle; an instruction offered in the same cycle is dropped. in_ready still reflects the formula.
- Register file:
  - Read addresses are rs1=inst[19:15] and rs2=inst[24:20]; reads are combinational at accept.
  - Write happens at the clk edge when wb_en && wb_rd!=0.
  - x0 always reads 0.
  - Without the optional feature, a same-cycle write to a register being read returns the old value.
- Immediates (all sign-extended from inst[31]):
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
- Operand selection by opcode:
  - 0110111 LUI: Op1=0, Op2=immU
  - 0010111 AUIPC: Op1=pc, Op2=immU
  - 0010011 OP-IMM: Op1=rs1, Op2=immI
  - 0110011 OP: Op1=rs1, Op2=rs2
  - 0000011 LOAD: Op1=rs1, Op2=immI
  - 0100011 STORE: Op1=rs1, Op2=immS
  - 1100011 BRANCH: Op1=rs1, Op2=rs2, out_imm=immB
  - 1101111 JAL: Op1=pc, Op2=4, out_imm=immJ
  - 1100111 JALR: Op1=pc, Op2=4, out_imm=immI
  - Any other opcode: out_illegal=1, Op1=Op2=out_imm=0, instruction still passes with out_valid.
- out_imm equals the selected-format immediate for every legal opcode.
- funct3/funct7 are passed raw; the ALU decodes them.
- out_rd=inst[11:7] raw, including for STORE and BRANCH.

Optional Feature:
- Macro: RV_DEC_BYPASS_EN.
- When defined: if wb_en && wb_rd!=0 && wb_rd matches rs1/rs2 at the accept cycle, wb_data is forwarded into Op1/Op2/out_rs1_val/out_rs2_val.
- When undefined: no forwarding; the old register value is captured.

Test Plan:
- Reset, then accept 0x000050b7 with pc=0 -> next cycle: out_valid=1, opcode=0x37, Op1=0, Op2=0x00005000, out_rd=1, out_illegal=0.
- wb x1=0x5000, then next cycle accept 0x00508193 -> Op1=0x5000, Op2=5, funct3=0, out_rd=3. Repeat with the wb in the same cycle as accept: Op1=0 without RV_DEC_BYPASS_EN, 0x5000 with it.
- Branch and jump immediates:
  - 0xfe000ce3 at pc=0x100 -> Op1=0, Op2=0, out_imm=0xfffffff8.
  - 0xff9ff2ef at pc=0x20 -> Op1=0x20, Op2=4, out_imm=0xfffffff8, out_rd=5.
- Backpressure: out_ready=0 for 3 cycles while a second instruction (0x00502083) is offered -> in_ready=0 and outputs constant. Release -> first consumed, then second appears with Op1=0, Op2=5; order preserved, no duplicate.
- Flush asserted in the same cycle as an accept -> out_valid=0 next cycle. wb_en with wb_rd=0, wb_data=0xdeadbeef, then read x0 -> 0.
- Accept 0x0000007f -> out_illegal=1, Op1=Op2=out_imm=0. Assert rst_n=0 mid-stall -> out_valid=0 next cycle and register file cleared.

Source files
------------

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - RISC-V decode/operand-fetch stage with 32x32 register file
// Optional writeback forwarding into the operand read path: define RV_DEC_BYPASS_EN.
module rv_decode_stage #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] Op1,
   output logic [XLEN-1:0] Op2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic            accept;
   logic            take;
   logic            rf_we;

   logic [XLEN-1:0] rf_q [32];
   logic [XLEN-1:0] rf_d [32];

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] dec_op1;
   logic [XLEN-1:0] dec_op2;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   logic            valid_q,   valid_d;
   logic [6:0]      opcode_q,  opcode_d;
   logic [2:0]      funct3_q,  funct3_d;
   logic [6:0]      funct7_q,  funct7_d;
   logic [XLEN-1:0] op1_q,     op1_d;
   logic [XLEN-1:0] op2_q,     op2_d;
   logic [XLEN-1:0] imm_q,     imm_d;
   logic [XLEN-1:0] rs1_val_q, rs1_val_d;
   logic [XLEN-1:0] rs2_val_q, rs2_val_d;
   logic [4:0]      rd_q,      rd_d;
   logic [XLEN-1:0] pc_q,      pc_d;
   logic            illegal_q, illegal_d;

   assign rs1_addr = in_inst[19:15];
   assign rs2_addr = in_inst[24:20];

   // The stage can take a new instruction whenever its output slot is empty or draining.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   // A redirect drops whatever is being offered in the same cycle.
   assign take     = accept && !flush;
   assign rf_we    = wb_en && (wb_rd != 5'd0);

   // Register-file next state: single writeback port, x0 never written.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         rf_d[i] = rf_q[i];
      end
      if (rf_we) begin
         rf_d[wb_rd] = wb_data;
      end
   end

   // Register-file storage, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   // Combinational operand read; x0 is hard-wired to zero.
   always_comb begin
      rs1_val = (rs1_addr == 5'd0) ? '0 : rf_q[rs1_addr];
      rs2_val = (rs2_addr == 5'd0) ? '0 : rf_q[rs2_addr];
`ifdef RV_DEC_BYPASS_EN
      if (rf_we && (wb_rd == rs1_addr)) begin
         rs1_val = wb_data;
      end
      if (rf_we && (wb_rd == rs2_addr)) begin
         rs2_val = wb_data;
      end
`endif
   end

   // Immediate formats, all sign-extended from inst[31].
   always_comb begin
      imm_i = XLEN'($signed(in_inst[31:20]));
      imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
      imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
   end

   // Operand and immediate selection by major opcode; unknown opcodes pass through zeroed.
   always_comb begin
      dec_op1     = '0;
      dec_op2     = '0;
      dec_imm     = '0;
      dec_illegal = 1'b0;
      case (in_inst[6:0])
         OPC_LUI: begin
            dec_op2 = imm_u;
            dec_imm = imm_u;
         end
         OPC_AUIPC: begin
            dec_op1 = in_pc;
            dec_op2 = imm_u;
            dec_imm = imm_u;
         end
         OPC_OP_IMM, OPC_LOAD: begin
            dec_op1 = rs1_val;
            dec_op2 = imm_i;
            dec_imm = imm_i;
         end
         OPC_OP: begin
            dec_op1 = rs1_val;
            dec_op2 = rs2_val;
            dec_imm = imm_i;
         end
         OPC_STORE: begin
            dec_op1 = rs1_val;
            dec_op2 = imm_s;
            dec_imm = imm_s;
         end
         OPC_BRANCH: begin
            dec_op1 = rs1_val;
            dec_op2 = rs2_val;
            dec_imm = imm_b;
         end
         OPC_JAL: begin
            dec_op1 = in_pc;
            dec_op2 = XLEN'(4);
            dec_imm = imm_j;
         end
         OPC_JALR: begin
            dec_op1 = in_pc;
            dec_op2 = XLEN'(4);
            dec_imm = imm_i;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   // Output register next state: load on take, otherwise hold so a stall keeps outputs stable.
   always_comb begin
      valid_d   = valid_q;
      opcode_d  = opcode_q;
      funct3_d  = funct3_q;
      funct7_d  = funct7_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      imm_d     = imm_q;
      rs1_val_d = rs1_val_q;
      rs2_val_d = rs2_val_q;
      rd_d      = rd_q;
      pc_d      = pc_q;
      illegal_d = illegal_q;

      if (flush) begin
         valid_d = 1'b0;
      end else if (take) begin
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end

      if (take) begin
         opcode_d  = in_inst[6:0];
         funct3_d  = in_inst[14:12];
         funct7_d  = in_inst[31:25];
         op1_d     = dec_op1;
         op2_d     = dec_op2;
         imm_d     = dec_imm;
         rs1_val_d = rs1_val;
         rs2_val_d = rs2_val;
         rd_d      = in_inst[11:7];
         pc_d      = in_pc;
         illegal_d = dec_illegal;
      end
   end

   // Output pipeline register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         imm_q     <= '0;
         rs1_val_q <= '0;
         rs2_val_q <= '0;
         rd_q      <= '0;
         pc_q      <= RESET_PC_VAL;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         opcode_q  <= opcode_d;
         funct3_q  <= funct3_d;
         funct7_q  <= funct7_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         imm_q     <= imm_d;
         rs1_val_q <= rs1_val_d;
         rs2_val_q <= rs2_val_d;
         rd_q      <= rd_d;
         pc_q      <= pc_d;
         illegal_q <= illegal_d;
      end
   end

   assign out_valid   = valid_q;
   assign opcode      = opcode_q;
   assign funct3      = funct3_q;
   assign funct7      = funct7_q;
   assign Op1         = op1_q;
   assign Op2         = op2_q;
   assign out_imm     = imm_q;
   assign out_rs1_val = rs1_val_q;
   assign out_rs2_val = rs2_val_q;
   assign out_rd      = rd_q;
   assign out_pc      = pc_q;
   assign out_illegal = illegal_q;

endmodule
